// File: rtl/iob_plic2_pkg.sv
// Shared constants, register-select encoding and width helpers for iob_plic2.
package iob_plic2_pkg;

  // Byte-offset bases of the register regions
  localparam logic [31:0] CONFIG_ADDR = 32'h0000_0000;
  localparam logic [31:0] EL_BASE     = 32'h0000_0100;
  localparam logic [31:0] IP_BASE     = 32'h0000_0200;
  localparam logic [31:0] PRIO_BASE   = 32'h0000_0400;
  localparam logic [31:0] IE_BASE     = 32'h0000_1000;
  localparam logic [31:0] CTX_BASE    = 32'h0000_2000;

  // Offsets inside a per-target context block
  localparam logic [3:0] CTX_THR_OFF   = 4'h0;
  localparam logic [3:0] CTX_CLAIM_OFF = 4'h4;

  // CONFIG field layout
  localparam int unsigned CFG_SRC_LSB  = 0;
  localparam int unsigned CFG_TGT_LSB  = 16;
  localparam int unsigned CFG_PRIO_LSB = 24;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_CONFIG,
    SEL_EL,
    SEL_IP,
    SEL_PRIO,
    SEL_IE,
    SEL_THR,
    SEL_CLAIM
  } reg_sel_e;

  // 32-bit words needed to hold IDs 0..sources
  function automatic int unsigned plic_nw(input int unsigned sources);
    return (sources + 32) / 32;
  endfunction

  function automatic int unsigned plic_prio_bits(input int unsigned priorities);
    return $clog2(priorities);
  endfunction

  function automatic int unsigned plic_src_bits(input int unsigned sources);
    return $clog2(sources + 1);
  endfunction

  function automatic int unsigned plic_cnt_bits(input int unsigned max_pending);
    return $clog2(max_pending + 1);
  endfunction

endpackage

// File: rtl/iob_plic2_gateway.sv
// Per-source interrupt gateway: edge/level qualification, saturating edge
// counter and in-service flag.
module iob_plic2_gateway
  import iob_plic2_pkg::*;
#(
  parameter int unsigned MAX_PENDING_COUNT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic el,
  input  logic el_clr,
  input  logic sw_set,
  input  logic claim,
  input  logic complete,
  output logic ip,
  output logic inservice
);

  localparam int unsigned CW = plic_cnt_bits(MAX_PENDING_COUNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PENDING_COUNT);

  logic          src_q;
  logic          is_q;
  logic [CW-1:0] cnt;
  logic          inc;

  // Edge events (hardware rising edge or software set) count only in edge mode
  always_comb begin
    inc = el & ((src & ~src_q) | sw_set);
  end

  // Input sampling, in-service flag and saturating pending counter
  always_ff @(posedge clk) begin
    if (rst) begin
      src_q <= 1'b0;
      is_q  <= 1'b0;
      cnt   <= '0;
    end else begin
      src_q <= src;
      if (claim) begin
        is_q <= 1'b1;
      end else if (complete) begin
        is_q <= 1'b0;
      end
      if (el_clr) begin
        cnt <= '0;
      end else if (el) begin
        // simultaneous edge and claim cancel out
        if (inc && !claim && cnt != CNT_MAX) begin
          cnt <= cnt + 1'b1;
        end else if (claim && !inc && cnt != '0) begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

  // Pending view presented to the arbiters
  always_comb begin
    if (el) begin
      ip = (cnt != '0) & ~is_q;
    end else begin
      ip = src_q & ~is_q;
    end
    inservice = is_q;
  end

endmodule

// File: rtl/iob_plic2.sv
// Platform-level interrupt controller on the IOb native bus: register file,
// bus decode, per-target arbitration and claim/complete handling.
module iob_plic2
  import iob_plic2_pkg::*;
#(
  parameter int unsigned ADDR_W            = 16,
  parameter int unsigned DATA_W            = 32,
  parameter int unsigned SOURCES           = 64,
  parameter int unsigned TARGETS           = 4,
  parameter int unsigned PRIORITIES        = 8,
  parameter int unsigned MAX_PENDING_COUNT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                valid,
  input  logic [ADDR_W-1:0]   address,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic [DATA_W-1:0]   rdata,
  output logic                ready,
  input  logic [SOURCES-1:0]  src,
  output logic [TARGETS-1:0]  irq
);

  localparam int unsigned NW = plic_nw(SOURCES);
  localparam int unsigned VW = NW * 32;
  localparam int unsigned PB = plic_prio_bits(PRIORITIES);
  localparam int unsigned SW = plic_src_bits(SOURCES);

  // Bits of the packed ID vectors that correspond to real sources (ID 0 excluded)
  localparam logic [VW-1:0] ONE_V   = 1;
  localparam logic [VW-1:0] ID_MASK = (ONE_V << (SOURCES + 1)) - (ONE_V << 1);

  localparam logic [31:0] CONFIG_VAL = (32'(PRIORITIES - 1) << CFG_PRIO_LSB) |
                                       (32'(TARGETS) << CFG_TGT_LSB) |
                                       (32'(SOURCES) << CFG_SRC_LSB);

  logic [31:0]      a32;
  reg_sel_e         sel;
  int unsigned      word;
  int unsigned      tgt;
  int unsigned      pid;
  logic             rd_en;
  logic             wr_en;
  logic [31:0]      bmask;

  logic [VW-1:0]    el_r;
  logic [VW-1:0]    el_nxt;
  logic [VW-1:0]    ie_r   [TARGETS];
  logic [PB-1:0]    prio_r [1:SOURCES];
  logic [PB-1:0]    thr_r  [TARGETS];

  logic [SW-1:0]    id_q   [TARGETS];
  logic [SOURCES:1] oh_q   [TARGETS];
  logic [SW-1:0]    arb_id [TARGETS];
  logic [SOURCES:1] arb_oh [TARGETS];

  logic [SOURCES:1] gw_ip;
  logic [SOURCES:1] gw_is;
  logic [SOURCES:1] el_clr;
  logic [SOURCES:1] sw_set;
  logic [SOURCES:1] claim_v;
  logic [SOURCES:1] complete_v;
  logic [VW-1:0]    ip_v;

  logic [SW-1:0]    cl_id;
  logic [SOURCES:1] cl_oh;
  logic             claim_ok;

  logic [31:0]      rd_data;
  logic [31:0]      rdata_q;
  logic             ready_q;
  logic [TARGETS-1:0] irq_q;

  assign a32 = 32'(address);

  // Address decode into a register region plus word/target/ID indices
  always_comb begin
    sel   = SEL_NONE;
    word  = 0;
    tgt   = 0;
    pid   = 0;
    rd_en = valid & ~(|wstrb);
    wr_en = valid & (|wstrb);
    bmask = {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
    if (a32[1:0] == 2'b00) begin
      if (a32 == CONFIG_ADDR) begin
        sel = SEL_CONFIG;
      end else if ((a32 & ~32'h0000_00FF) == EL_BASE) begin
        word = 32'(a32[7:2]);
        if (word < NW) sel = SEL_EL;
      end else if ((a32 & ~32'h0000_00FF) == IP_BASE) begin
        word = 32'(a32[7:2]);
        if (word < NW) sel = SEL_IP;
      end else if ((a32 & ~32'h0000_03FF) == PRIO_BASE) begin
        pid = 32'(a32[9:2]);
        if (pid != 0 && pid <= SOURCES) sel = SEL_PRIO;
      end else if ((a32 & ~32'h0000_07FF) == IE_BASE) begin
        tgt  = 32'(a32[10:7]);
        word = 32'(a32[6:2]);
        if (tgt < TARGETS && word < NW) sel = SEL_IE;
      end else if ((a32 & ~32'h0000_00FF) == CTX_BASE) begin
        tgt = 32'(a32[7:4]);
        if (tgt < TARGETS) begin
          if (a32[3:0] == CTX_THR_OFF) sel = SEL_THR;
          else if (a32[3:0] == CTX_CLAIM_OFF) sel = SEL_CLAIM;
        end
      end
    end
  end

  // Write-side strobes toward the gateways: EL updates, software sets, completes
  always_comb begin
    el_nxt     = el_r;
    el_clr     = '0;
    sw_set     = '0;
    complete_v = '0;
    for (int unsigned w = 0; w < NW; w++) begin
      if (wr_en && sel == SEL_EL && word == w) begin
        el_nxt[w*32 +: 32] = (el_r[w*32 +: 32] & ~bmask) | (wdata & bmask);
      end
    end
    el_nxt = el_nxt & ID_MASK;
    for (int unsigned i = 1; i <= SOURCES; i++) begin
      el_clr[i]     = el_nxt[i] ^ el_r[i];
      sw_set[i]     = wr_en && sel == SEL_IP && word == i / 32 &&
                      bmask[i % 32] && wdata[i % 32] && el_r[i];
      complete_v[i] = wr_en && sel == SEL_CLAIM && wdata[7:0] == 8'(i) && gw_is[i];
    end
  end

  // Claim qualification: the registered winner must still be pending right now
  always_comb begin
    cl_id = '0;
    cl_oh = '0;
    for (int unsigned t = 0; t < TARGETS; t++) begin
      if (tgt == t) begin
        cl_id = id_q[t];
        cl_oh = oh_q[t];
      end
    end
    claim_ok = rd_en && sel == SEL_CLAIM && cl_id != '0 && (|(cl_oh & gw_ip));
    claim_v  = claim_ok ? cl_oh : '0;
  end

  // Pending bits packed in bus word layout (ID 0 reads as zero)
  always_comb begin
    ip_v = '0;
    ip_v[SOURCES:1] = gw_ip;
  end

  // Per-target arbitration; starting from the threshold folds the threshold
  // test into the strict priority compare, which also keeps the lowest ID on ties
  always_comb begin
    logic [PB-1:0] best_p;
    best_p = '0;
    for (int unsigned t = 0; t < TARGETS; t++) begin
      best_p    = thr_r[t];
      arb_id[t] = '0;
      arb_oh[t] = '0;
      for (int unsigned i = 1; i <= SOURCES; i++) begin
        if (gw_ip[i] && ie_r[t][i] && prio_r[i] > best_p) begin
          best_p       = prio_r[i];
          arb_id[t]    = SW'(i);
          arb_oh[t]    = '0;
          arb_oh[t][i] = 1'b1;
        end
      end
    end
  end

  // Read data multiplexer
  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      case (sel)
        SEL_CONFIG: rd_data = CONFIG_VAL;
        SEL_EL: begin
          for (int unsigned w = 0; w < NW; w++)
            if (word == w) rd_data = el_r[w*32 +: 32];
        end
        SEL_IP: begin
          for (int unsigned w = 0; w < NW; w++)
            if (word == w) rd_data = ip_v[w*32 +: 32];
        end
        SEL_PRIO: begin
          for (int unsigned i = 1; i <= SOURCES; i++)
            if (pid == i) rd_data = 32'(prio_r[i]);
        end
        SEL_IE: begin
          for (int unsigned t = 0; t < TARGETS; t++)
            for (int unsigned w = 0; w < NW; w++)
              if (tgt == t && word == w) rd_data = ie_r[t][w*32 +: 32];
        end
        SEL_THR: begin
          for (int unsigned t = 0; t < TARGETS; t++)
            if (tgt == t) rd_data = 32'(thr_r[t]);
        end
        SEL_CLAIM: rd_data = claim_ok ? 32'(cl_id) : '0;
        default: rd_data = '0;
      endcase
    end
  end

  // Register file, bus response and registered arbiter outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b0;
      rdata_q <= '0;
      el_r    <= '0;
      irq_q   <= '0;
      for (int unsigned i = 1; i <= SOURCES; i++) prio_r[i] <= '0;
      for (int unsigned t = 0; t < TARGETS; t++) begin
        ie_r[t]  <= '0;
        thr_r[t] <= '0;
        id_q[t]  <= '0;
        oh_q[t]  <= '0;
      end
    end else begin
      ready_q <= valid;
      rdata_q <= rd_data;
      el_r    <= el_nxt;
      if (wr_en) begin
        case (sel)
          SEL_PRIO: begin
            for (int unsigned i = 1; i <= SOURCES; i++)
              if (pid == i && wstrb[0]) prio_r[i] <= wdata[PB-1:0];
          end
          SEL_IE: begin
            for (int unsigned t = 0; t < TARGETS; t++)
              for (int unsigned w = 0; w < NW; w++)
                if (tgt == t && word == w)
                  ie_r[t][w*32 +: 32] <= ((ie_r[t][w*32 +: 32] & ~bmask) |
                                          (wdata & bmask)) & ID_MASK[w*32 +: 32];
          end
          SEL_THR: begin
            for (int unsigned t = 0; t < TARGETS; t++)
              if (tgt == t && wstrb[0]) thr_r[t] <= wdata[PB-1:0];
          end
          default: ;
        endcase
      end
      for (int unsigned t = 0; t < TARGETS; t++) begin
        id_q[t]  <= arb_id[t];
        oh_q[t]  <= arb_oh[t];
        irq_q[t] <= (arb_id[t] != '0);
      end
    end
  end

  assign rdata = rdata_q;
  assign ready = ready_q;
  assign irq   = irq_q;

  // One gateway per source; source ID g is fed by src[g-1]
  for (genvar g = 1; g <= SOURCES; g++) begin : g_gw
    iob_plic2_gateway #(
      .MAX_PENDING_COUNT(MAX_PENDING_COUNT)
    ) u_gw (
      .clk      (clk),
      .rst      (rst),
      .src      (src[g-1]),
      .el       (el_r[g]),
      .el_clr   (el_clr[g]),
      .sw_set   (sw_set[g]),
      .claim    (claim_v[g]),
      .complete (complete_v[g]),
      .ip       (gw_ip[g]),
      .inservice(gw_is[g])
    );
  end

endmodule

// File: tb/tb_iob_plic2.sv
// Directed self-checking bench for iob_plic2 (64 sources, 4 targets, 8 levels,
// edge counter saturating at 2).
module tb_iob_plic2;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [15:0] address;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;
  logic        ready;
  logic [63:0] src;
  logic [3:0]  irq;

  int checks   = 0;
  int failures = 0;

  localparam logic [15:0] A_CONFIG = 16'h0000;
  localparam logic [15:0] A_EL0    = 16'h0100;
  localparam logic [15:0] A_IP0    = 16'h0200;
  localparam logic [15:0] A_IE0    = 16'h1000;
  localparam logic [15:0] A_THR0   = 16'h2000;
  localparam logic [15:0] A_CLAIM0 = 16'h2004;

  iob_plic2 #(
    .ADDR_W(16),
    .DATA_W(32),
    .SOURCES(64),
    .TARGETS(4),
    .PRIORITIES(8),
    .MAX_PENDING_COUNT(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid(valid),
    .address(address),
    .wdata(wdata),
    .wstrb(wstrb),
    .rdata(rdata),
    .ready(ready),
    .src(src),
    .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write_s(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
    @(negedge clk);
    valid = 1'b1; address = a; wdata = d; wstrb = s;
    @(posedge clk);
    #1;
    valid = 1'b0; wstrb = 4'h0;
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [31:0] d);
    bus_write_s(a, d, 4'hF);
  endtask

  task automatic bus_read(input logic [15:0] a, output logic [31:0] d, output logic rdy);
    @(negedge clk);
    valid = 1'b1; address = a; wstrb = 4'h0;
    @(posedge clk);
    #1;
    d = rdata; rdy = ready;
    valid = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [15:0] a, input logic [31:0] exp);
    logic [31:0] d;
    logic        r;
    bus_read(a, d, r);
    check(tag, d, exp);
  endtask

  task automatic pulse_src(input int idx);
    @(negedge clk); src[idx] = 1'b1;
    @(negedge clk); src[idx] = 1'b0;
  endtask

  function automatic logic [15:0] prio_addr(input int id);
    return 16'(16'h0400 + 4 * id);
  endfunction

  initial begin
    logic [31:0] d;
    logic [31:0] d2;
    logic        r;

    rst = 1'b1; valid = 1'b0; address = '0; wdata = '0; wstrb = '0; src = '0;
    tick(3);
    check("reset_irq", 32'(irq), 32'h0);
    check("reset_ready", 32'(ready), 32'h0);
    check("reset_rdata", rdata, 32'h0);
    @(negedge clk); rst = 1'b0;

    bus_read(A_CONFIG, d, r);
    check("config", d, 32'h0704_0040);
    check("read_ready", 32'(r), 32'h1);
    read_check("unmapped", 16'h3000, 32'h0);
    bus_write(16'h1200, 32'hFFFF_FFFF);            // IE of target 4: out of range
    read_check("ie_tgt4", 16'h1200, 32'h0);
    bus_write_s(A_EL0, 32'hFFFF_FFFF, 4'b0011);    // bytes 0,1 only; ID 0 stays 0
    read_check("el_bytes", A_EL0, 32'h0000_FFFE);
    bus_write(A_EL0, 32'h0);

    // Level source ID 3, exact delivery latency, claim and re-assert on complete
    bus_write(prio_addr(3), 32'd2);
    bus_write(A_IE0, 32'h0000_0008);
    bus_write(A_THR0, 32'd0);
    @(negedge clk); src[2] = 1'b1;
    tick(1);
    check("lvl_irq_lat1", 32'(irq[0]), 32'h0);
    tick(1);
    check("lvl_irq_lat2", 32'(irq[0]), 32'h1);
    read_check("lvl_claim", A_CLAIM0, 32'd3);
    tick(1);
    check("lvl_irq_fall", 32'(irq[0]), 32'h0);
    bus_write(A_CLAIM0, 32'd3);
    check("lvl_cpl_lat1", 32'(irq[0]), 32'h0);
    tick(1);
    check("lvl_cpl_lat2", 32'(irq[0]), 32'h1);
    @(negedge clk); src[2] = 1'b0;
    bus_write(A_IE0, 32'h0);
    tick(2);

    // Edge ID 5: four pulses saturate at two pending events
    bus_write(A_EL0, 32'h0000_0020);
    bus_write(prio_addr(5), 32'd1);
    bus_write(A_IE0, 32'h0000_0020);
    for (int k = 0; k < 4; k++) pulse_src(4);
    tick(3);
    read_check("edge_claim1", A_CLAIM0, 32'd5);
    bus_write(A_CLAIM0, 32'd5);
    tick(3);
    read_check("edge_claim2", A_CLAIM0, 32'd5);
    bus_write(A_CLAIM0, 32'd5);
    tick(3);
    read_check("edge_claim3", A_CLAIM0, 32'd0);
    check("edge_irq_idle", 32'(irq[0]), 32'h0);

    // Priority ordering and lowest-ID tie-break, then threshold masking
    bus_write(prio_addr(4), 32'd3);
    bus_write(prio_addr(9), 32'd3);
    bus_write(prio_addr(7), 32'd5);
    bus_write(A_IE0, 32'h0000_0290);
    @(negedge clk); src[3] = 1'b1; src[6] = 1'b1; src[8] = 1'b1;
    tick(3);
    read_check("prio_first", A_CLAIM0, 32'd7);
    tick(2);
    read_check("prio_second", A_CLAIM0, 32'd4);
    tick(2);
    read_check("prio_third", A_CLAIM0, 32'd9);
    tick(1);
    check("prio_all_busy", 32'(irq[0]), 32'h0);
    bus_write(A_CLAIM0, 32'd7);
    bus_write(A_CLAIM0, 32'd4);
    bus_write(A_CLAIM0, 32'd9);
    bus_write(A_THR0, 32'd5);
    tick(3);
    check("thr_irq", 32'(irq[0]), 32'h0);
    read_check("thr_claim", A_CLAIM0, 32'd0);
    read_check("thr_ip", A_IP0, 32'h0000_0290);
    @(negedge clk); src[3] = 1'b0; src[6] = 1'b0; src[8] = 1'b0;
    bus_write(A_THR0, 32'd0);

    // Back-to-back claims, then complete of a non-claimed ID
    bus_write(A_IE0, 32'h0000_0020);
    pulse_src(4);
    tick(3);
    @(negedge clk);
    valid = 1'b1; address = A_CLAIM0; wstrb = 4'h0;
    @(posedge clk); #1; d = rdata;
    @(posedge clk); #1; d2 = rdata;
    valid = 1'b0;
    check("b2b_first", d, 32'd5);
    check("b2b_second", d2, 32'd0);
    pulse_src(4);
    bus_write(A_CLAIM0, 32'd6);
    tick(3);
    check("bad_cpl_irq", 32'(irq[0]), 32'h0);
    bus_write(A_CLAIM0, 32'd5);
    tick(3);
    check("good_cpl_irq", 32'(irq[0]), 32'h1);
    read_check("good_cpl_claim", A_CLAIM0, 32'd5);
    bus_write(A_CLAIM0, 32'd5);

    // Software set: honoured for edge ID 10, ignored for level ID 11
    bus_write(A_EL0, 32'h0000_0420);
    bus_write(prio_addr(10), 32'd1);
    bus_write(prio_addr(11), 32'd1);
    bus_write(A_IE0, 32'h0000_0C00);
    bus_write(A_IP0, 32'h0000_0400);
    tick(3);
    check("sw_edge_irq", 32'(irq[0]), 32'h1);
    read_check("sw_edge_claim", A_CLAIM0, 32'd10);
    bus_write(A_CLAIM0, 32'd10);
    tick(3);
    check("sw_edge_done", 32'(irq[0]), 32'h0);
    bus_write(A_IP0, 32'h0000_0800);
    tick(3);
    check("sw_level_irq", 32'(irq[0]), 32'h0);
    read_check("sw_level_ip", A_IP0, 32'h0);

    // Reset while ID 2 is in service; a same-cycle access is dropped
    bus_write(prio_addr(2), 32'd1);
    bus_write(A_IE0, 32'h0000_0004);
    @(negedge clk); src[1] = 1'b1;
    tick(3);
    read_check("rst_pre_claim", A_CLAIM0, 32'd2);
    @(negedge clk);
    rst = 1'b1; valid = 1'b1; address = A_CONFIG; wstrb = 4'h0;
    @(posedge clk); #1;
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_ready", 32'(ready), 32'h0);
    check("rst_rdata", rdata, 32'h0);
    @(negedge clk); rst = 1'b0; valid = 1'b0;
    read_check("rst_config", A_CONFIG, 32'h0704_0040);
    read_check("rst_ie", A_IE0, 32'h0);
    read_check("rst_prio", prio_addr(2), 32'h0);
    read_check("rst_el", A_EL0, 32'h0);
    tick(3);
    check("rst_irq_after", 32'(irq), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'h0, 32'h1);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iob_plic2.md
# iob_plic2

Parametrised second-generation platform-level interrupt controller on the IOb native bus. Per-source gateways support edge or level mode with saturating edge counters and software-triggered pending. Per-target arbiters apply enable masks, a priority threshold and lowest-ID tie-break, then drive a registered `irq` and interrupt ID. The block sits between peripheral interrupt lines and up to 16 harts/targets, with claim/complete handled through bus reads and writes.

## Interface
- `ADDR_W`, 16: byte-address width; map below fits in 14 bits.
- `DATA_W`, 32: fixed at 32.
- `SOURCES`, 64: interrupt sources, 1..255; source ID `i+1` maps to `src[i]`, ID 0 is reserved.
- `TARGETS`, 4: interrupt targets, 1..16.
- `PRIORITIES`, 8: priority levels, 2..256; `PRIORITY_BITS = $clog2(PRIORITIES)`.
- `MAX_PENDING_COUNT`, 8: edge-counter saturation value, ≥1.
- `clk` in 1: sole clock.
- `rst` in 1: reset, synchronous, active-high.
- `valid` in 1: bus request, one access per asserted cycle.
- `address` in ADDR_W: byte address, word-aligned.
- `wdata` in 32: write data.
- `wstrb` in 4: byte enables; all-zero means read.
- `rdata` out 32: registered read data.
- `ready` out 1: registered acknowledge.
- `src` in SOURCES: interrupt lines, synchronous to `clk`.
- `irq` out TARGETS: registered interrupt request per target.

## Operation
Word count `NW = ceil((SOURCES+1)/32)`. IP and IE bit `b` of word `w` is ID `32w+b`; ID 0 bits read 0.

Address map (byte offsets):
- 0x0000 CONFIG, RO: [15:0]=SOURCES, [23:16]=TARGETS, [31:24]=PRIORITIES-1.
- 0x0100+4w EL, RW: 1=edge, 0=level.
- 0x0200+4w IP, read returns pending. Write-1 to an edge-mode ID acts as a synthetic edge. Write-1 to a level-mode ID is ignored.
- 0x0400+4·id PRIORITY, RW, PRIORITY_BITS wide. Priority 0 means the source is never delivered.
- 0x1000+0x80t+4w IE for target t, RW.
- 0x2000+0x10t THRESHOLD for target t, RW.
- 0x2004+0x10t CLAIM/COMPLETE for target t.
- Unmapped or out-of-range addresses read 0; writes to them are ignored.
- Byte enables apply to RW registers. On CLAIM/COMPLETE, any nonzero `wstrb` is a full write.

Gateway per source:
- Level mode: `ip = src & ~inservice`.
- Edge mode:
  - A rising edge of registered `src`, or a software set, increments the counter, saturating at MAX_PENDING_COUNT; excess edges are dropped.
  - `ip = (cnt != 0) & ~inservice`.
- Claim sets `inservice` and decrements `cnt` if edge mode. An edge and a claim in the same cycle leave `cnt` unchanged.
- Complete clears `inservice`.
- Changing EL clears `cnt`.

Arbiter per target, recomputed every cycle:
- Candidates are IDs with `ip & ie` and priority > threshold.
- The highest priority wins; ties go to the lowest ID.
- Registered outputs: `id[t]` = winner or 0, and `irq[t] = (id[t] != 0)`.

Claim (read of CLAIM t):
- If `id[t] != 0` and `ip[id[t]]` is still set: return `id[t]` and apply the claim side-effects at that edge.
- Otherwise return 0 with no side-effects. This blocks stale back-to-back claims.

Complete (write of CLAIM t):
- `wdata[7:0]`=ID. If the ID is in range and `inservice`, clear `inservice`; otherwise ignore.

## Timing
- `ready <= valid`: one cycle of latency, zero wait states. `rdata` is valid only in the `ready` cycle.
- `src` high sampled at edge k → gateway pending at k+1 → `irq`/`id` at k+2.
- A claim at edge k clears `ip` at k. `irq` deasserts at k+1 unless another candidate exists.
- A register write at edge k affects the arbiter result at k+1.
- Reset values are all zero: `rdata`, `ready`, `irq`, EL, IP, counters, `inservice`, PRIORITY, IE, THRESHOLD, `id`.
- Reset mid-operation discards every pending, in-service and counter state. A `valid` in the same cycle as `rst` is dropped (`ready`=0).

## Structure
- Package `iob_plic2_pkg`:
  - Address base constants and the CONFIG field layout.
  - Width helpers: `NW`, `PRIORITY_BITS`, `SOURCES_BITS`, `CNT_BITS = $clog2(MAX_PENDING_COUNT+1)`.
- Sub-module `iob_plic2_gateway`: one per source, containing edge detect, saturating counter and `inservice` flag.
- Top level holds the register file, bus decode, per-target arbiter generate loop and claim/complete logic.

## Test plan
- Level source ID 3, priority 2, IE t0, threshold 0; `src[2]` high → `irq[0]`=1 at cycle 2. CLAIM t0 reads 3 and `irq[0]` falls. Complete 3 with `src` still high → `irq[0]` re-asserts 2 cycles later.
- Edge ID 5, MAX_PENDING_COUNT=2; 4 pulses → exactly 2 claim/complete rounds return 5, and a third claim returns 0.
- IDs 4 and 9 at priority 3, ID 7 at priority 5; claims return 7, 4, 9. With threshold 5, `irq` stays 0 for all.
- Back-to-back CLAIM reads in consecutive cycles with one pending ID → 5, 0. Complete of a non-claimed ID is ignored.
- IP write-1 to edge ID 10 → `irq` asserts and the claim returns 10. The same write to a level ID has no effect.
- `rst` asserted while ID 2 is in service → all outputs 0 next cycle, CONFIG reads `{7,4,64}`, and IE is 0.
